sim_run_monitor: RTL and testbench

Simulation run controller and end-of-test monitor for the RV32I cores, replacing fixed-length clock/reset/stop loops in testbenches. It holds the core in reset for a programmable number of cycles, then counts cycles and retired instructions. It detects test completion through a store to a "tohost" address, and enforces a cycle timeout. A bench instantiates it beside `top` and calls `$stop` or `$finish` on `done`. The RTL is synthesizable, so it can also be reused on FPGA builds with LEDs driven from `pass`/`done`.

---
 rtl/sim_run_monitor.sv | 134 +++++++++++++
 tb/tb_sim_run_monitor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sim_run_monitor.sv
// sim_run_monitor
//   Run controller and end-of-test monitor for the RV32I cores. It holds the
//   core in reset for RESET_CYCLES cycles after the system reset is released.
//   It then counts run cycles and retired instructions. The run finishes on a
//   valid store to TOHOST_ADDR (bit 0 set) or when MAX_CYCLES run cycles have
//   elapsed.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   mem_we       core data-memory write enable
//   mem_addr     core data-memory address
//   mem_wdata    core data-memory write data
//   retire       one pulse per retired instruction
//   core_reset   reset driven into the core (high in HOLD and DONE)
//   running      high in RUN
//   done         sticky finish flag
//   pass         finished with exit code 0
//   timeout      finished by cycle timeout
//   exit_code    mem_wdata[31:1] of the terminating write
//   cycle_cnt    RUN cycles elapsed (saturating)
//   instret_cnt  retire pulses seen in RUN (saturating)
module sim_run_monitor #(
  parameter int          RESET_CYCLES = 2,
  parameter int          MAX_CYCLES   = 21,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0100,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             retire,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      exit_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYCLE_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic              done_next, pass_next, timeout_next;
  logic [30:0]       exit_code_next;
  logic [CNT_W-1:0]  cycle_cnt_next, instret_cnt_next;
  logic              tohost_hit;

  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];

  always_comb begin
    state_next       = state;
    hold_cnt_next    = hold_cnt;
    done_next        = done;
    pass_next        = pass;
    timeout_next     = timeout;
    exit_code_next   = exit_code;
    cycle_cnt_next   = cycle_cnt;
    instret_cnt_next = instret_cnt;
    case (state)
      HOLD: begin
        hold_cnt_next = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Counters advance on the terminating edge as well.
        if (cycle_cnt != {CNT_W{1'b1}}) begin
          cycle_cnt_next = cycle_cnt + 1'b1;
        end
        if (retire && (instret_cnt != {CNT_W{1'b1}})) begin
          instret_cnt_next = instret_cnt + 1'b1;
        end
        // A tohost write on the timeout edge takes priority.
        if (tohost_hit) begin
          state_next     = DONE;
          done_next      = 1'b1;
          exit_code_next = mem_wdata[31:1];
          pass_next      = (mem_wdata[31:1] == 31'd0);
        end else if ((MAX_CYCLES != 0) && (cycle_cnt == CYCLE_LAST)) begin
          state_next   = DONE;
          done_next    = 1'b1;
          timeout_next = 1'b1;
          pass_next    = 1'b0;
        end
      end
      default: begin
        state_next = DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      core_reset  <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      exit_code   <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      // Registered from the next state so these track the FSM with no lag.
      core_reset  <= (state_next != RUN);
      running     <= (state_next == RUN);
      done        <= done_next;
      pass        <= pass_next;
      timeout     <= timeout_next;
      exit_code   <= exit_code_next;
      cycle_cnt   <= cycle_cnt_next;
      instret_cnt <= instret_cnt_next;
    end
  end

endmodule

// File: tb/tb_sim_run_monitor.sv
// tb_sim_run_monitor
//   Directed bench for sim_run_monitor with default parameters, plus a second
//   instance with MAX_CYCLES=0 that runs with no tohost write.
module tb_sim_run_monitor;

  logic        clk = 1'b0;
  logic        reset, reset0;
  logic        mem_we, mem_we0;
  logic [31:0] mem_addr, mem_wdata;
  logic        retire;

  logic        core_reset, running, done, pass, timeout;
  logic [30:0] exit_code;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        core_reset0, running0, done0, pass0, timeout0;
  logic [30:0] exit_code0;
  logic [31:0] cycle_cnt0, instret_cnt0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sim_run_monitor dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .retire(retire), .core_reset(core_reset),
    .running(running), .done(done), .pass(pass), .timeout(timeout),
    .exit_code(exit_code), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  sim_run_monitor #(.MAX_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset0), .mem_we(mem_we0), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .retire(retire), .core_reset(core_reset0),
    .running(running0), .done(done0), .pass(pass0), .timeout(timeout0),
    .exit_code(exit_code0), .cycle_cnt(cycle_cnt0), .instret_cnt(instret_cnt0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge; outputs sampled and inputs changed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic cr, input logic run,
                             input logic dn, input logic ps, input logic to,
                             input logic [30:0] ec, input logic [31:0] cc,
                             input logic [31:0] ic);
    $display("step %s: core_reset=%0b running=%0b done=%0b pass=%0b timeout=%0b exit=%0d cyc=%0d inst=%0d",
             tag, core_reset, running, done, pass, timeout, exit_code, cycle_cnt, instret_cnt);
    check({tag, ".core_reset"}, {31'd0, core_reset}, {31'd0, cr});
    check({tag, ".running"},    {31'd0, running},    {31'd0, run});
    check({tag, ".done"},       {31'd0, done},       {31'd0, dn});
    check({tag, ".pass"},       {31'd0, pass},       {31'd0, ps});
    check({tag, ".timeout"},    {31'd0, timeout},    {31'd0, to});
    check({tag, ".exit_code"},  {1'b0, exit_code},   {1'b0, ec});
    check({tag, ".cycle_cnt"},  cycle_cnt,           cc);
    check({tag, ".instret_cnt"}, instret_cnt,        ic);
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  task automatic idle();
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
  endtask

  // Reset for one edge then release; returns at the first RUN cycle.
  task automatic restart();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; reset0 = 1'b1;
    mem_we0 = 1'b0; retire = 1'b0;
    idle();
    #1;

    // 1: reset for 3 edges, then 2 hold edges; hold-time write ignored
    repeat (3) step();
    check_state("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; reset0 = 1'b0;
    write(32'h100, 32'h1);
    retire = 1'b1;
    step();
    check_state("hold1", 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_state("run0", 0, 1, 0, 0, 0, 0, 0, 0);
    idle();

    // 2 + 5a/5b: retire every cycle, ignored writes, pass at cycle 7
    step(); step();
    write(32'h104, 32'h1);
    step();
    check_state("wrong_addr", 0, 1, 0, 0, 0, 0, 3, 3);
    write(32'h100, 32'h2);
    step();
    check_state("bit0_clear", 0, 1, 0, 0, 0, 0, 4, 4);
    idle();
    step(); step(); step();
    check("pre_pass.cycle_cnt", cycle_cnt, 32'd7);
    write(32'h100, 32'h1);
    step();
    check_state("pass", 1, 0, 1, 1, 0, 0, 8, 8);
    write(32'h100, 32'h2B);
    repeat (5) step();
    check_state("pass_hold", 1, 0, 1, 1, 0, 0, 8, 8);
    idle();

    // 3: non-zero exit code
    retire = 1'b0;
    restart();
    write(32'h100, 32'h2B);
    step();
    check_state("fail_code", 1, 0, 1, 0, 0, 21, 1, 0);
    idle();

    // 6: five retire pulses in ten cycles, then reset mid-run
    restart();
    for (int i = 0; i < 10; i++) begin
      retire = (i % 2 == 0);
      step();
    end
    retire = 1'b0;
    check_state("retire5", 0, 1, 0, 0, 0, 0, 10, 5);
    reset = 1'b1;
    step();
    check_state("mid_reset", 1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(); step();
    check_state("rerun0", 0, 1, 0, 0, 0, 0, 0, 0);

    // 4: timeout with no write
    repeat (20) step();
    check_state("pre_timeout", 0, 1, 0, 0, 0, 0, 20, 0);
    step();
    check_state("timeout", 1, 0, 1, 0, 1, 0, 21, 0);
    repeat (3) step();
    check_state("timeout_hold", 1, 0, 1, 0, 1, 0, 21, 0);

    // 5d: valid write on the timeout edge wins
    restart();
    repeat (20) step();
    write(32'h100, 32'h1);
    step();
    check_state("edge_write", 1, 0, 1, 1, 0, 0, 21, 0);
    idle();

    // 4b: MAX_CYCLES=0 instance has never seen a write
    repeat (30) step();
    $display("step no_timeout: done=%0b running=%0b cyc=%0d", done0, running0, cycle_cnt0);
    check("no_timeout.done", {31'd0, done0}, 32'd0);
    check("no_timeout.running", {31'd0, running0}, 32'd1);
    check("no_timeout.ge100", {31'd0, (cycle_cnt0 >= 32'd100)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
